// File: rtl/flash_audio_reader.sv
// flash_audio_reader: turns rising edges of the divided sample clock into 8-bit samples, two per 32-bit flash word, walked forward or backward.
// Waits on flash_waitrequest with address held; optional PAUSE_MUTE_EN zeroes audio_data while play is low.
module flash_audio_reader #(
    parameter int                ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic              play,
    input  logic              direction,
    input  logic              restart,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_read,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [7:0]        audio_data,
    output logic              audio_valid,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, HALF} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, hist_q;
    logic              tick, go;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_tgt_q, addr_q, addr_d, restart_tgt, step_addr;
    logic [7:0]        audio_q, second_q;
    logic              audio_valid_q, underrun_q;
    logic              first_en, second_en, load_tgt, use_pend, set_pend;
    logic              unused_low_bytes;

    assign tick        = sync2_q & ~hist_q;
    assign go          = tick & play;
    assign restart_tgt = direction ? LAST_ADDR : '0;
    assign step_addr   = direction ? ((addr_q == '0) ? LAST_ADDR : addr_q - ADDR_W'(1))
                                   : ((addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1));
    // Only the high byte of each 16-bit PCM sample is played.
    assign unused_low_bytes = ^{flash_readdata[23:16], flash_readdata[7:0]};

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!restart && go) state_d = READ;
            READ:      if (!flash_waitrequest) state_d = WAIT_DATA;
            WAIT_DATA: if (flash_readdatavalid) state_d = (pend_q || restart) ? IDLE : HALF;
            HALF:      if (restart || go) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        flash_read = 1'b0;
        first_en   = 1'b0;
        second_en  = 1'b0;
        load_tgt   = 1'b0;
        use_pend   = 1'b0;
        set_pend   = 1'b0;
        case (state_q)
            IDLE: load_tgt = restart;
            READ: begin
                flash_read = 1'b1;
                set_pend   = restart;
            end
            WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    // A restart seen during the transaction discards the returned word.
                    if (pend_q || restart) begin
                        load_tgt = 1'b1;
                        use_pend = !restart;
                    end else begin
                        first_en = 1'b1;
                    end
                end else begin
                    set_pend = restart;
                end
            end
            HALF: begin
                if (restart) load_tgt = 1'b1;
                else if (go) second_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (load_tgt)       addr_d = use_pend ? pend_tgt_q : restart_tgt;
        else if (second_en) addr_d = step_addr;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            hist_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_tgt_q    <= '0;
            addr_q        <= '0;
            audio_q       <= 8'h00;
            second_q      <= 8'h00;
            audio_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sync1_q       <= sample_clk;
            sync2_q       <= sync1_q;
            hist_q        <= sync2_q;
            addr_q        <= addr_d;
            audio_valid_q <= first_en | second_en;
            if (set_pend) begin
                pend_q     <= 1'b1;
                pend_tgt_q <= restart_tgt;
            end else if (load_tgt) begin
                pend_q     <= 1'b0;
            end
            if (first_en) begin
                audio_q  <= direction ? flash_readdata[31:24] : flash_readdata[15:8];
                second_q <= direction ? flash_readdata[15:8]  : flash_readdata[31:24];
            end else if (second_en) begin
                audio_q  <= second_q;
            end
            if (tick && (state_q == READ || state_q == WAIT_DATA)) underrun_q <= 1'b1;
        end
    end

`ifdef PAUSE_MUTE_EN
    logic mute_q;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= ~play;
        end
    end

    assign audio_data = mute_q ? 8'h00 : audio_q;
`else
    assign audio_data = audio_q;
`endif

    assign flash_addr  = addr_q;
    assign audio_valid = audio_valid_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// Bench for flash_audio_reader: directed test-plan cases with literal expectations, then a randomized run,
// all checked every cycle against a behavioural model of sample fetching.
`timescale 1ns/1ps
module tb_flash_audio_reader;
    localparam int            AW   = 23;
    localparam logic [AW-1:0] LAST = 23'h7FFFF;

    logic          clk_50 = 1'b0;
    logic          reset = 1'b1, sample_clk = 1'b0, play = 1'b0, direction = 1'b0, restart = 1'b0;
    logic [AW-1:0] flash_addr;
    logic          flash_read;
    logic          flash_waitrequest = 1'b0;
    logic [31:0]   flash_readdata = 32'h0;
    logic          flash_readdatavalid = 1'b0;
    logic [7:0]    audio_data;
    logic          audio_valid, underrun;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    always #10 clk_50 = ~clk_50;

    flash_audio_reader #(.ADDR_W(AW), .LAST_ADDR(LAST)) dut (
        .clk_50(clk_50), .reset(reset), .sample_clk(sample_clk), .play(play),
        .direction(direction), .restart(restart), .flash_addr(flash_addr),
        .flash_read(flash_read), .flash_waitrequest(flash_waitrequest),
        .flash_readdata(flash_readdata), .flash_readdatavalid(flash_readdatavalid),
        .audio_data(audio_data), .audio_valid(audio_valid), .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- flash slave ----------------
    logic [31:0] mem [int];
    typedef struct { logic [31:0] data; int due; } ret_t;
    ret_t          ret_q[$];
    logic [AW-1:0] acc_q[$];
    int cyc = 0, wait_left = 0, wait_cfg = 0, lat_cfg = 2, stale_req = 0, stale_done = 0;
    bit rand_mode = 1'b0, in_req = 1'b0;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {a[7:0] ^ 8'h5A, a[15:8] + 8'h31, ~a[7:0], a[7:0] + 8'h17};
    endfunction

    always @(negedge clk_50) begin
        int lat;
        cyc++;
        flash_readdatavalid = 1'b0;
        flash_readdata      = $urandom;
        if (stale_req != stale_done) begin
            stale_done          = stale_req;
            flash_readdatavalid = 1'b1;
            flash_readdata      = 32'hDEADBEEF;
        end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            flash_readdatavalid = 1'b1;
            flash_readdata      = ret_q[0].data;
            void'(ret_q.pop_front());
        end else if (rand_mode && ret_q.size() == 0 && $urandom_range(0, 15) == 0) begin
            flash_readdatavalid = 1'b1;
        end
        if (!flash_read) begin
            in_req            = 1'b0;
            flash_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = rand_mode ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (wait_left > 0) begin
                flash_waitrequest = 1'b1;
                wait_left--;
            end else begin
                flash_waitrequest = 1'b0;
                in_req            = 1'b0;
                lat = rand_mode ? int'($urandom_range(1, 6)) : lat_cfg;
                ret_q.push_back('{data: word_of(flash_addr), due: cyc + lat});
                acc_q.push_back(flash_addr);
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit            m_s1, m_s2, m_h, m_req, m_wait, m_half, m_pend, m_valid, m_under, m_mute;
    logic [AW-1:0] m_addr, m_ptgt;
    logic [7:0]    m_audio, m_second;

    always @(posedge clk_50) begin
        bit            tick, go;
        logic [AW-1:0] tgt;
        logic [31:0]   w;
        int            n, a;
        if (reset) begin
            {m_s1, m_s2, m_h, m_req, m_wait, m_half, m_pend, m_valid, m_under, m_mute} = '0;
            m_addr = '0; m_ptgt = '0; m_audio = 8'h00; m_second = 8'h00;
        end else begin
            tick = m_s2 && !m_h;
            m_h = m_s2; m_s2 = m_s1; m_s1 = sample_clk;
            go      = tick && play;
            tgt     = direction ? LAST : '0;
            w       = flash_readdata;
            m_valid = 1'b0;
            if (m_req) begin
                if (tick) m_under = 1'b1;
                if (restart) begin m_pend = 1'b1; m_ptgt = tgt; end
                if (!flash_waitrequest) begin m_req = 1'b0; m_wait = 1'b1; end
            end else if (m_wait) begin
                if (tick) m_under = 1'b1;
                if (flash_readdatavalid) begin
                    m_wait = 1'b0;
                    if (restart) m_addr = tgt;
                    else if (m_pend) m_addr = m_ptgt;
                    else begin
                        m_audio  = direction ? w[31:24] : w[15:8];
                        m_second = direction ? w[15:8]  : w[31:24];
                        m_valid  = 1'b1;
                        m_half   = 1'b1;
                    end
                    m_pend = 1'b0;
                end else if (restart) begin
                    m_pend = 1'b1; m_ptgt = tgt;
                end
            end else if (m_half) begin
                if (restart) begin
                    m_half = 1'b0; m_addr = tgt;
                end else if (go) begin
                    m_half  = 1'b0;
                    m_audio = m_second;
                    m_valid = 1'b1;
                    n = int'(LAST) + 1;
                    a = (int'(m_addr) + (direction ? n - 1 : 1)) % n;
                    m_addr = a[AW-1:0];
                end
            end else begin
                if (restart) m_addr = tgt;
                else if (go) m_req = 1'b1;
            end
            m_mute = !play;
        end
    end

    always @(negedge clk_50) begin
        logic [7:0] exp_audio;
`ifdef PAUSE_MUTE_EN
        exp_audio = m_mute ? 8'h00 : m_audio;
`else
        exp_audio = m_audio;
`endif
        if (chk_en) begin
            check("flash_read", flash_read, m_req);
            check("flash_addr", flash_addr, m_addr);
            check("audio_valid", audio_valid, m_valid);
            check("audio_data", audio_data, exp_audio);
            check("underrun", underrun, m_under);
        end
    end

    // ---------------- observation ----------------
    logic [7:0] seen_q[$];
    int rd_cycles = 0;
    always @(negedge clk_50) begin
        if (audio_valid) seen_q.push_back(audio_data);
        if (flash_read) rd_cycles++;
    end

    task automatic do_tick();
        sample_clk = 1'b1;
        repeat (4) @(negedge clk_50);
        sample_clk = 1'b0;
        repeat (8) @(negedge clk_50);
    endtask

    task automatic wait_read(input logic lvl, input string name);
        int n = 0;
        while (flash_read !== lvl && n < 200) begin
            @(negedge clk_50);
            n++;
        end
        check(name, flash_read, lvl);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, a0, r0, half;
        logic [7:0] x;
        mem[0] = 32'hA1B2C3D4;
        repeat (3) @(negedge clk_50);
        check("rst_flash_addr", flash_addr, 0);
        check("rst_flash_read", flash_read, 0);
        check("rst_audio_data", audio_data, 0);
        check("rst_audio_valid", audio_valid, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0; chk_en = 1'b1; play = 1'b1;
        repeat (2) @(negedge clk_50);

        // forward play from address 0
        base = seen_q.size(); a0 = acc_q.size();
        do_tick(); do_tick();
        check("fwd_nvalid", seen_q.size() - base, 2);
        if (seen_q.size() >= base + 2) begin
            check("fwd_first", seen_q[base], 8'hC3);
            check("fwd_second", seen_q[base + 1], 8'hA1);
        end
        if (acc_q.size() > a0) check("fwd_read_addr", acc_q[a0], 0);
        check("fwd_addr", flash_addr, 1);

        // restart forward, then backward wrap from 0
        restart = 1'b1; @(negedge clk_50); restart = 1'b0; @(negedge clk_50);
        check("restart_fwd_addr", flash_addr, 0);
        mem[0] = 32'h11223344; direction = 1'b1;
        base = seen_q.size();
        do_tick(); do_tick();
        check("bwd_nvalid", seen_q.size() - base, 2);
        if (seen_q.size() >= base + 2) begin
            check("bwd_first", seen_q[base], 8'h11);
            check("bwd_second", seen_q[base + 1], 8'h33);
        end
        check("bwd_wrap_addr", flash_addr, 23'h7FFFF);

        // forward wrap from the last address
        direction = 1'b0; a0 = acc_q.size();
        do_tick(); do_tick();
        if (acc_q.size() > a0) check("fwdwrap_read_addr", acc_q[a0], 23'h7FFFF);
        check("fwdwrap_addr", flash_addr, 0);

        // waitrequest for 5 cycles, data 4 cycles later, a tick lands in the wait
        wait_cfg = 5; lat_cfg = 4; r0 = rd_cycles; base = seen_q.size();
        sample_clk = 1'b1;
        wait_read(1'b1, "wait_read_start");
        sample_clk = 1'b0;
        repeat (2) @(negedge clk_50);
        sample_clk = 1'b1;
        repeat (4) @(negedge clk_50);
        sample_clk = 1'b0;
        repeat (20) @(negedge clk_50);
        check("wait_read_cycles", rd_cycles - r0, 6);
        check("wait_nvalid", seen_q.size() - base, 1);
        check("wait_underrun", underrun, 1);
        wait_cfg = 0; lat_cfg = 2;
        do_tick();
        check("wait_done_addr", flash_addr, 1);

        // advance to address 7, then restart while the read is outstanding
        for (int i = 0; i < 12; i++) do_tick();
        check("reach_addr7", flash_addr, 7);
        lat_cfg = 6; base = seen_q.size();
        sample_clk = 1'b1;
        wait_read(1'b1, "rs_read_start");
        wait_read(1'b0, "rs_read_accept");
        restart = 1'b1; @(negedge clk_50); restart = 1'b0;
        sample_clk = 1'b0;
        repeat (15) @(negedge clk_50);
        check("rs_nvalid", seen_q.size() - base, 0);
        check("rs_addr", flash_addr, 0);
        lat_cfg = 2; a0 = acc_q.size();
        do_tick();
        if (acc_q.size() > a0) check("rs_idle_read", acc_q[a0], 0);
        do_tick();

        // reset during READ, then a stale return
        wait_cfg = 10;
        sample_clk = 1'b1;
        wait_read(1'b1, "rr_read_start");
        reset = 1'b1; sample_clk = 1'b0;
        @(negedge clk_50);
        check("rr_flash_read", flash_read, 0);
        check("rr_flash_addr", flash_addr, 0);
        check("rr_audio_data", audio_data, 0);
        check("rr_audio_valid", audio_valid, 0);
        check("rr_underrun", underrun, 0);
        reset = 1'b0; wait_cfg = 0;
        base = seen_q.size();
        stale_req++;
        repeat (10) @(negedge clk_50);
        check("stale_nvalid", seen_q.size() - base, 0);
        check("stale_audio", audio_data, 0);
        check("stale_idle", flash_read, 0);

        // pause behaviour
        base = seen_q.size();
        do_tick();
        x = (seen_q.size() > base) ? seen_q[base] : 8'h00;
        check("pause_first", x, 8'h33);
        play = 1'b0;
        repeat (2) @(negedge clk_50);
`ifdef PAUSE_MUTE_EN
        check("pause_audio", audio_data, 8'h00);
`else
        check("pause_audio", audio_data, x);
`endif
        play = 1'b1;
        repeat (2) @(negedge clk_50);
        check("resume_audio", audio_data, x);
        do_tick();

        // randomized run
        rand_mode = 1'b1; half = 4;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_50);
            restart = ($urandom_range(0, 99) == 0);
            play    = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 149) == 0) direction = ~direction;
            half--;
            if (half == 0) begin
                sample_clk = ~sample_clk;
                half = $urandom_range(2, 14);
            end
        end
        rand_mode = 1'b0; restart = 1'b0; play = 1'b1; sample_clk = 1'b0;
        repeat (30) @(negedge clk_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
